// File: rtl/ll_sc_reservation_ctrl_pkg.sv
// Shared definitions for the LL/SC reservation controller.
package ll_sc_reservation_ctrl_pkg;

    // Reservation state: IDLE holds nothing, LINKED holds link_addr and ages it.
    typedef enum logic {
        RSV_IDLE   = 1'b0,
        RSV_LINKED = 1'b1
    } rsv_state_e;

    // Default reservation lifetime in cycles and a counter wide enough to reach it.
    localparam int RSV_TIMEOUT = 1024;
    localparam int RSV_CNT_W   = 11;

endpackage

// File: rtl/ll_sc_reservation_ctrl.sv
// LL/SC reservation tracker for the 5-stage MIPS core.
// Holds one link address, drops it on stores, snoop writes, flushes and
// timeout, and tells decode (with same-cycle bypass) whether an SC may store.
module ll_sc_reservation_ctrl
    import ll_sc_reservation_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int GRAN_LSB = 2,
    parameter int TIMEOUT  = RSV_TIMEOUT,
    parameter int CNT_W    = RSV_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ll_ex,
    input  logic              sc_ex,
    input  logic              store_ex,
    input  logic [ADDR_W-1:0] addr_ex,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              atomic_id,
    output logic              mem_sc_mask_id,
    output logic              link_valid,
    output logic [ADDR_W-1:0] link_addr
);

    localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    rsv_state_e        state_q, state_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic set_ex;
    logic kill_ex;
    logic kill_snoop;
    logic set_snoop_hit;
    logic timeout_hit;

    // Two addresses fall in the same granule when they differ only below GRAN_LSB.
    function automatic logic granule_eq(input logic [ADDR_W-1:0] a,
                                        input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] diff;
        diff = (a ^ b) >> GRAN_LSB;
        return (diff == '0);
    endfunction

    // Qualify the EX-stage and snoop events that can change the reservation.
    always_comb begin
        set_ex        = ex_valid & ll_ex;
        kill_ex       = ex_valid & (sc_ex | store_ex);
        kill_snoop    = snoop_we & (state_q == RSV_LINKED) & granule_eq(snoop_addr, link_addr_q);
        set_snoop_hit = snoop_we & granule_eq(snoop_addr, addr_ex);
        timeout_hit   = TIMEOUT_EN & (cnt_q == CNT_LAST);
    end

    // Next-state, link address and age counter, highest priority event first.
    always_comb begin
        state_d     = state_q;
        link_addr_d = link_addr_q;
        cnt_d       = cnt_q;
        if (rst) begin
            state_d     = RSV_IDLE;
            link_addr_d = '0;
            cnt_d       = '0;
        end else if (flush) begin
            state_d = RSV_IDLE;
        end else if (set_ex) begin
            link_addr_d = addr_ex;
            cnt_d       = '0;
            state_d     = set_snoop_hit ? RSV_IDLE : RSV_LINKED;
        end else if (kill_ex || kill_snoop) begin
            state_d = RSV_IDLE;
        end else if (state_q == RSV_LINKED) begin
            if (timeout_hit) begin
                state_d = RSV_IDLE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Reservation registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RSV_IDLE;
            link_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            link_addr_q <= link_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Decode sees the reservation as it will be after this cycle's EX event.
    assign atomic_id      = (state_d == RSV_LINKED);
    assign mem_sc_mask_id = ~atomic_id;
    assign link_valid     = (state_q == RSV_LINKED);
    assign link_addr      = link_addr_q;

endmodule

// File: tb/tb_ll_sc_reservation_ctrl.sv
// Bench for ll_sc_reservation_ctrl: directed vector table, timeout and
// saturation sequences, then random traffic against a reservation model.
module tb_ll_sc_reservation_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid, ll_ex, sc_ex, store_ex, snoop_we;
    logic [31:0] addr_ex, snoop_addr;

    logic [1:0]  atomic_w, mask_w, lv_w;
    logic [31:0] la_w [2];

    int checks = 0;
    int errors = 0;

    // Reservation model state per unit: unit 0 has an 8-cycle lifetime, unit 1 none.
    bit          m_valid [2];
    logic [31:0] m_addr  [2];
    int          m_age   [2];
    int          tmo     [2] = '{8, 0};

    typedef struct {
        logic        rst, flush, ex_valid, ll, sc, store, swe;
        logic [31:0] addr, saddr;
        logic        exp_atomic, exp_lv, chk_la;
        logic [31:0] exp_la;
    } vec_t;

    vec_t tbl [$];

    // 10 ns core clock.
    always #5 clk = ~clk;

    ll_sc_reservation_ctrl #(.ADDR_W(32), .GRAN_LSB(2), .TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ll_ex(ll_ex),
        .sc_ex(sc_ex), .store_ex(store_ex), .addr_ex(addr_ex), .snoop_we(snoop_we),
        .snoop_addr(snoop_addr), .atomic_id(atomic_w[0]), .mem_sc_mask_id(mask_w[0]),
        .link_valid(lv_w[0]), .link_addr(la_w[0])
    );

    ll_sc_reservation_ctrl #(.ADDR_W(32), .GRAN_LSB(2), .TIMEOUT(0), .CNT_W(4)) dut_nt (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ll_ex(ll_ex),
        .sc_ex(sc_ex), .store_ex(store_ex), .addr_ex(addr_ex), .snoop_we(snoop_we),
        .snoop_addr(snoop_addr), .atomic_id(atomic_w[1]), .mem_sc_mask_id(mask_w[1]),
        .link_valid(lv_w[1]), .link_addr(la_w[1])
    );

    function automatic vec_t mk(input logic r, f, ev, ll, sc, st,
                                input logic [31:0] a, input logic swe, input logic [31:0] sa,
                                input logic ea, elv, chk, input logic [31:0] ela);
        vec_t v;
        v.rst = r; v.flush = f; v.ex_valid = ev; v.ll = ll; v.sc = sc; v.store = st;
        v.addr = a; v.swe = swe; v.saddr = sa;
        v.exp_atomic = ea; v.exp_lv = elv; v.chk_la = chk; v.exp_la = ela;
        return v;
    endfunction

    // Drive one cycle of inputs just after the falling edge, then settle.
    task automatic applyStimulus(input logic r, f, ev, ll, sc, st,
                                 input logic [31:0] a, input logic swe, input logic [31:0] sa);
        @(negedge clk);
        rst = r; flush = f; ex_valid = ev; ll_ex = ll; sc_ex = sc; store_ex = st;
        addr_ex = a; snoop_we = swe; snoop_addr = sa;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkUnit(input string tag, input int i, input logic ea, input logic elv,
                             input logic chk, input logic [31:0] ela);
        checkOutput($sformatf("%s_u%0d_atomic", tag, i), {31'b0, atomic_w[i]}, {31'b0, ea});
        checkOutput($sformatf("%s_u%0d_mask", tag, i), {31'b0, mask_w[i]}, {31'b0, ~ea});
        checkOutput($sformatf("%s_u%0d_link_valid", tag, i), {31'b0, lv_w[i]}, {31'b0, elv});
        if (chk) checkOutput($sformatf("%s_u%0d_link_addr", tag, i), la_w[i], ela);
    endtask

    function automatic bit sameWord(input logic [31:0] a, input logic [31:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    // Reservation rules applied to the current inputs: where it will stand after this edge.
    task automatic predict(input int i, output bit nv, output logic [31:0] na, output int nage);
        nv = m_valid[i]; na = m_addr[i]; nage = m_age[i];
        if (rst) begin
            nv = 0; na = '0; nage = 0;
        end else if (flush) begin
            nv = 0;
        end else if (ex_valid && ll_ex) begin
            na = addr_ex; nage = 0;
            nv = !(snoop_we && sameWord(snoop_addr, addr_ex));
        end else if (ex_valid && (sc_ex || store_ex)) begin
            nv = 0;
        end else if (m_valid[i] && snoop_we && sameWord(snoop_addr, m_addr[i])) begin
            nv = 0;
        end else if (m_valid[i]) begin
            nage = m_age[i] + 1;
            if (tmo[i] != 0 && nage >= tmo[i]) nv = 0;
        end
    endtask

    initial begin
        bit          nv;
        logic [31:0] na;
        int          nage;
        logic [31:0] ra, rsa;
        int          kind;

        // Directed vectors: inputs for one cycle, expected atomic_id and pre-edge link state.
        tbl.push_back(mk(1,0,0,0,0,0,32'h000,0,32'h000, 0,0,1,32'h000)); // reset held
        tbl.push_back(mk(0,0,1,1,0,0,32'h100,0,32'h000, 1,0,0,32'h000)); // LL: bypass
        tbl.push_back(mk(0,0,1,0,1,0,32'h100,0,32'h000, 0,1,1,32'h100)); // SC in EX clears
        tbl.push_back(mk(0,0,0,0,0,0,32'h000,0,32'h000, 0,0,0,32'h000));
        tbl.push_back(mk(0,0,1,1,0,0,32'h100,0,32'h000, 1,0,0,32'h000)); // LL
        tbl.push_back(mk(0,0,1,0,0,1,32'h200,0,32'h000, 0,1,1,32'h100)); // SW other addr
        tbl.push_back(mk(0,0,0,0,0,0,32'h000,0,32'h000, 0,0,0,32'h000)); // SC in ID masked
        tbl.push_back(mk(0,0,1,1,0,0,32'h100,0,32'h000, 1,0,0,32'h000)); // LL
        tbl.push_back(mk(0,0,0,0,0,0,32'h000,1,32'h104, 1,1,1,32'h100)); // snoop next word
        tbl.push_back(mk(0,0,0,0,0,0,32'h000,1,32'h102, 0,1,1,32'h100)); // snoop same word
        tbl.push_back(mk(0,0,0,0,0,0,32'h000,0,32'h000, 0,0,0,32'h000));
        tbl.push_back(mk(0,0,1,1,0,0,32'h100,0,32'h000, 1,0,0,32'h000)); // LL
        tbl.push_back(mk(0,0,0,0,0,0,32'h000,1,32'h104, 1,1,1,32'h100)); // SC in ID ok
        tbl.push_back(mk(0,0,1,0,1,0,32'h100,0,32'h000, 0,1,1,32'h100)); // SC in EX
        tbl.push_back(mk(0,0,1,0,1,0,32'h100,0,32'h000, 0,0,0,32'h000)); // second SC fails
        tbl.push_back(mk(0,0,1,1,0,0,32'h100,1,32'h100, 0,0,0,32'h000)); // LL + snoop hit
        tbl.push_back(mk(0,0,0,0,0,0,32'h000,0,32'h000, 0,0,0,32'h000)); // SC masked
        tbl.push_back(mk(0,1,1,1,0,0,32'h300,0,32'h000, 0,0,0,32'h000)); // flush beats LL
        tbl.push_back(mk(0,0,0,0,0,0,32'h000,0,32'h000, 0,0,0,32'h000));
        tbl.push_back(mk(0,0,1,1,0,0,32'h300,0,32'h000, 1,0,0,32'h000)); // LL
        tbl.push_back(mk(1,0,0,0,0,0,32'h000,0,32'h000, 0,1,1,32'h300)); // rst while LINKED
        tbl.push_back(mk(0,0,0,0,0,0,32'h000,1,32'h000, 0,0,1,32'h000)); // snoop while IDLE
        tbl.push_back(mk(0,0,0,1,0,0,32'h040,0,32'h000, 0,0,1,32'h000)); // LL on a bubble

        applyStimulus(1,0,0,0,0,0,32'h0,0,32'h0);
        applyStimulus(1,0,0,0,0,0,32'h0,0,32'h0);

        for (int k = 0; k < tbl.size(); k++) begin
            applyStimulus(tbl[k].rst, tbl[k].flush, tbl[k].ex_valid, tbl[k].ll, tbl[k].sc,
                          tbl[k].store, tbl[k].addr, tbl[k].swe, tbl[k].saddr);
            for (int i = 0; i < 2; i++)
                checkUnit($sformatf("vec%0d", k), i, tbl[k].exp_atomic, tbl[k].exp_lv,
                          tbl[k].chk_la, tbl[k].exp_la);
        end

        // Timeout on unit 0 (8 cycles) during a decode stall; unit 1 holds and saturates.
        applyStimulus(0,0,1,1,0,0,32'h180,0,32'h0);
        for (int i = 0; i < 2; i++) checkUnit("tmo_ll", i, 1, 0, 0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0,0,0,0,0,0,32'h0,0,32'h0);
            checkUnit($sformatf("tmo_hold%0d", k), 0, (k < 7), 1, 1, 32'h180);
            checkUnit($sformatf("nt_hold%0d", k), 1, 1, 1, 1, 32'h180);
        end
        applyStimulus(0,0,0,0,0,0,32'h0,0,32'h0);
        checkUnit("tmo_expired", 0, 0, 0, 0, 32'h0);
        for (int k = 8; k < 22; k++) begin
            applyStimulus(0,0,0,0,0,0,32'h0,0,32'h0);
            checkUnit($sformatf("nt_sat%0d", k), 1, 1, 1, 1, 32'h180);
        end
        applyStimulus(0,0,1,0,1,0,32'h180,0,32'h0);
        checkUnit("tmo_sc", 0, 0, 0, 0, 32'h0);
        checkUnit("nt_sc", 1, 0, 1, 1, 32'h180);
        applyStimulus(0,0,0,0,0,0,32'h0,0,32'h0);
        checkUnit("post_sc", 1, 0, 0, 0, 32'h0);

        // Random traffic on a small address pool so hits are frequent.
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_addr[i] = '0; m_age[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            kind = int'($urandom_range(0, 15));
            ra   = 32'h100 + $urandom_range(0, 15);
            rsa  = 32'h100 + $urandom_range(0, 15);
            applyStimulus((c == 0) || ($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 3) != 0),
                          (kind <= 2), (kind == 3), (kind == 4),
                          ra, ($urandom_range(0, 3) == 0), rsa);
            for (int i = 0; i < 2; i++) begin
                predict(i, nv, na, nage);
                checkUnit($sformatf("rnd%0d", c), i, nv, m_valid[i], m_valid[i], m_addr[i]);
                m_valid[i] = nv; m_addr[i] = na; m_age[i] = nage;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
